// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder.
// FSM states and handshake widths.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int BE_W  = 4;
  localparam int CNT_W = 4;

endpackage

// File: rtl/dm_array.sv
// Word array with byte write enables and a registered,
// byte-masked read port that clears when not enabled.
module dm_array
  import dm_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BE_W-1:0] wbe,
  input  logic [AW-1:0]   waddr,
  input  logic [31:0]     wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  input  logic [BE_W-1:0] rbe,
  output logic [31:0]     rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rmask;

  always_comb begin
    rmask = '0;
    for (int i = 0; i < BE_W; i++)
      rmask[8*i +: 8] = {8{rbe[i]}};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++)
      if (wbe[i])
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr] & rmask;
    else
      rdata <= '0;
  end

endmodule

// File: rtl/dm_responder.sv
// Multicycle data-memory responder with wait states.
// Optional DM_BOUNDS_CHECK_EN flags out-of-range addresses.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [BE_W-1:0] be,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            err
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     cap_idx;
  logic              cap_we;
  logic [BE_W-1:0]   cap_be;
  logic [31:0]       cap_wdata;
  logic              cap_oob;

  logic              start;
  logic              to_resp;
  logic              in_oob;
  logic              cur_we;
  logic              cur_oob;
  logic [AW-1:0]     cur_idx;
  logic [BE_W-1:0]   cur_be;
  logic [BE_W-1:0]   wbe;
  logic              re;
  logic              unused_addr;

`ifdef DM_BOUNDS_CHECK_EN
  assign in_oob      = |addr[31:AW+2];
  assign unused_addr = ^addr[1:0];
`else
  assign in_oob      = 1'b0;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

  assign start   = (state == ST_IDLE) && req;
  assign to_resp = (start && (WAIT_C == '0)) ||
                   ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  // With zero wait states the response is built from the live inputs.
  assign cur_idx = start ? addr[AW+1:2] : cap_idx;
  assign cur_be  = start ? be           : cap_be;
  assign cur_we  = start ? we           : cap_we;
  assign cur_oob = start ? in_oob       : cap_oob;

  assign re  = to_resp && !cur_we && !cur_oob;
  assign wbe = cap_be &
               {BE_W{(state == ST_RESP) && cap_we && !cap_oob}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_wdata <= '0;
      cap_oob   <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready <= to_resp;
      err   <= to_resp && cur_oob;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            cap_idx   <= addr[AW+1:2];
            cap_we    <= we;
            cap_be    <= be;
            cap_wdata <= wdata;
            cap_oob   <= in_oob;
            cnt       <= WAIT_C;
            state     <= (WAIT_C == '0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  dm_array #(.AW(AW)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wbe   (wbe),
    .waddr (cap_idx),
    .wdata (cap_wdata),
    .re    (re),
    .raddr (cur_idx),
    .rbe   (cur_be),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: transaction scoreboard plus
// directed vectors on a WAIT=2 and a WAIT=0 instance.
module tb_dm_responder;

  localparam int DL = 10;
  localparam int WT = 2;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        chk_on = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  be = 0;
  logic [31:0] rdata;
  logic        ready, err;

  logic        r0_req = 0, r0_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0;
  logic [3:0]  r0_be = 0;
  logic [31:0] r0_rdata;
  logic        r0_ready, r0_err;

  exp_t        q[$];
  exp_t        q0[$];
  logic [7:0]  mm [int];

  dm_responder #(.DEPTH_LOG2(DL), .WAIT(WT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err)
  );

  dm_responder #(.DEPTH_LOG2(DL), .WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req(r0_req), .we(r0_we),
    .addr(r0_addr), .be(r0_be), .wdata(r0_wdata),
    .rdata(r0_rdata), .ready(r0_ready), .err(r0_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: byte store, wrap or fault.
  task automatic model_push(input bit w,
                            input logic [31:0] a,
                            input logic [3:0] b,
                            input logic [31:0] d,
                            input int due);
    exp_t e;
    bit   oob;
    int   wi;
    int   k;
`ifdef DM_BOUNDS_CHECK_EN
    oob = (a >> (DL + 2)) != 0;
`else
    oob = 1'b0;
`endif
    wi = int'((a >> 2) % (32'd1 << DL));
    e.due = due;
    e.rd  = '0;
    e.er  = oob;
    if (!oob) begin
      for (int i = 0; i < 4; i++) begin
        k = wi * 4 + i;
        if (w && b[i])
          mm[k] = d[8*i +: 8];
        if (!w && b[i] && mm.exists(k))
          e.rd[8*i +: 8] = mm[k];
      end
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t        e;
      logic        eb;
      logic [31:0] er;
      logic        ee;
      eb = 0; er = 0; ee = 0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e  = q.pop_front();
        eb = (e.due == cyc);
        er = eb ? e.rd : 32'h0;
        ee = eb ? e.er : 1'b0;
      end
      chk("ready", {31'h0, ready}, {31'h0, eb});
      chk("rdata", rdata, er);
      chk("err", {31'h0, err}, {31'h0, ee});
      eb = 0; er = 0; ee = 0;
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        e  = q0.pop_front();
        eb = (e.due == cyc);
        er = eb ? e.rd : 32'h0;
        ee = eb ? e.er : 1'b0;
      end
      chk("w0_ready", {31'h0, r0_ready}, {31'h0, eb});
      chk("w0_rdata", r0_rdata, er);
      chk("w0_err", {31'h0, r0_err}, {31'h0, ee});
    end
  end

  task automatic wait_rdy(input bit s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s ? r0_ready : ready) && n < 40);
    chk("timeout", {31'h0, (s ? r0_ready : ready)}, 32'h1);
  endtask

  task automatic txn(input bit w,
                     input logic [31:0] a,
                     input logic [3:0] b,
                     input logic [31:0] d,
                     output logic [31:0] rd,
                     output logic er,
                     output int lat);
    int issue;
    @(posedge clk);
    #1;
    req = 1; we = w; addr = a; be = b; wdata = d;
    issue = cyc;
    model_push(w, a, b, d, issue + 1 + WT);
    wait_rdy(0);
    rd  = rdata;
    er  = err;
    lat = cyc - issue;
    req = 0;
  endtask

  logic [3:0]  bl [3] = '{4'hf, 4'h6, 4'h8};
  logic [31:0] el [3] = '{32'hCAFEF00D, 32'h00FEF000, 32'hCA000000};

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    exp_t        e0;

    #2 rst_n = 0;
    #1 chk_on = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    txn(0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    chk("lat0", lat, 32'd3);
    chk("ld0_rd", rd, 32'h0);
    chk("ld0_err", {31'h0, er}, 32'h0);

    txn(1, 32'h10, 4'hf, 32'hDEADBEEF, rd, er, lat);
    chk("st_rd", rd, 32'h0);
    txn(0, 32'h10, 4'hf, 32'h0, rd, er, lat);
    chk("ld_dead", rd, 32'hDEADBEEF);

    txn(1, 32'h12, 4'h1, 32'h000000AA, rd, er, lat);
    txn(0, 32'h10, 4'h3, 32'h0, rd, er, lat);
    chk("ld_beaa", rd, 32'h0000BEAA);

    txn(1, 32'h20, 4'hf, 32'h55AA55AA, rd, er, lat);
    txn(1, 32'h20, 4'h0, 32'hFFFFFFFF, rd, er, lat);
    @(posedge clk);
    #1;
    req = 1; we = 1; addr = 32'h20; be = 4'hf;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    rst_n = 0;
    q.delete();
    we = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    model_push(0, 32'h20, 4'hf, 32'h0, cyc + 1 + WT);
    wait_rdy(0);
    chk("ld_after_rst", rdata, 32'h55AA55AA);
    req = 0;

    txn(1, 32'h0, 4'hf, 32'hA5A5A5A5, rd, er, lat);
    txn(1, 32'h1000, 4'hf, 32'h11112222, rd, er, lat);
`ifdef DM_BOUNDS_CHECK_EN
    chk("oob_err", {31'h0, er}, 32'h1);
`else
    chk("oob_err", {31'h0, er}, 32'h0);
`endif
    txn(0, 32'h0, 4'hf, 32'h0, rd, er, lat);
`ifdef DM_BOUNDS_CHECK_EN
    chk("ld_word0", rd, 32'hA5A5A5A5);
`else
    chk("ld_word0", rd, 32'h11112222);
`endif

    txn(1, 32'hFFC, 4'ha, 32'h77665544, rd, er, lat);
    txn(0, 32'hFFC, 4'hf, 32'h0, rd, er, lat);
    chk("ld_top_hi", rd & 32'hFF00FF00, 32'h77005500);

    @(posedge clk);
    #1;
    r0_req = 1; r0_we = 1; r0_addr = 32'h40;
    r0_be = 4'hf; r0_wdata = 32'hCAFEF00D;
    e0 = '{cyc + 1, 32'h0, 1'b0};
    q0.push_back(e0);
    wait_rdy(1);
    for (int i = 0; i < 3; i++) begin
      r0_we = 0;
      r0_be = bl[i];
      e0 = '{cyc + 2, el[i], 1'b0};
      q0.push_back(e0);
      wait_rdy(1);
      chk("w0_ld", r0_rdata, el[i]);
    end
    r0_req = 0;

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multicycle data-memory responder: the memory-side end of the processor's data-memory interface. It accepts one load or store request at a time through a req/ready handshake, inserts a parameterised number of wait states, and applies per-byte write enables. It sits between the multicycle CPU datapath (DMWr/Be/ALU-address side) and a word-organised storage array, replacing the combinational memory model with a timed responder.

## Interface

- DEPTH_LOG2, 10, log2 of array depth in 32-bit words
- WAIT, 2, wait-state cycles between request capture and response (0..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request valid, held high by requester until ready
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address; bits [1:0] ignored
- be  in  4  byte enables, be[0] = bits [7:0]
- wdata  in  32  store data
- rdata  out  32  load data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  address fault, valid while ready=1

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: when req=1, capture addr, we, be, wdata; load wait counter with WAIT; go to WAIT if WAIT>0, else RESP.
- WAIT: counter decrements each cycle; at counter==1 go to RESP. req is not re-sampled; dropping req mid-transaction does not abort it.
- RESP: ready=1 for exactly one cycle; next state IDLE unconditionally. New request accepted no earlier than the IDLE cycle after RESP.
- Word index = captured addr[DEPTH_LOG2+1:2].
- Store: on the RESP clock edge, bytes with be[i]=1 written; others unchanged. be=4'b0000 completes with no change. rdata=0 for stores.
- Load: rdata byte i = array byte i if be[i]=1, else 8'h00.
- Storage array has no reset; contents undefined until written.

## Timing

- Reset values: state IDLE, ready=0, err=0, rdata=32'h0, wait counter 0, captured registers 0.
- Latency req-sampled-high to ready: WAIT+1 cycles (WAIT=0 -> ready in the cycle after capture).
- Throughput: one transaction per WAIT+2 cycles.
- ready, rdata, err are registered outputs; rdata/err return to 0 the cycle after RESP.
- Store visible to a load issued in the next transaction.
- rst_n low mid-transaction: immediate return to IDLE, outputs to reset values, pending store discarded (not written).
- req high while rst_n deasserts: captured on the first rising edge with rst_n=1.

## Configuration

- DM_BOUNDS_CHECK_EN defined: if captured addr[31:DEPTH_LOG2+2] is nonzero, RESP drives err=1, rdata=0, no array write. In-range accesses err=0.
- Not defined: upper address bits ignored (address wraps modulo array size); err tied 0.

## Structure

- Shared package dm_pkg: FSM state enum (IDLE, WAIT, RESP), byte-enable width constant, wait-counter width constant (4).
- Sub-module dm_array: synchronous word array with 4 byte write enables, registered read port; dm_responder holds FSM, counter, capture registers, and bounds logic.

## Test plan

- Reset then load from addr 32'h0 with WAIT=2 -> ready high exactly 3 cycles after req, single cycle, err=0.
- Store 32'hDEADBEEF be=4'b1111 to 32'h10, then load be=4'b1111 -> rdata=32'hDEADBEEF.
- Store 32'h000000AA be=4'b0001 to 32'h10 over DEADBEEF, load be=4'b0011 -> rdata=32'h0000BEAA.
- WAIT=0 back-to-back: req held high continuously -> ready every 2nd cycle, each transaction completes.
- Assert rst_n low during WAIT of store 32'h12345678 to 32'h20, then load 32'h20 -> prior contents unchanged, ready=0 throughout reset.
- With DM_BOUNDS_CHECK_EN, DEPTH_LOG2=10: store to 32'h00001000 -> err=1 with ready, load from 32'h0 shows no change; without macro, same store aliases word 0.
